// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control unit.
// Holds the state enum, supported opcodes and the ALU operand/operation codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXECUTE  = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // An instruction retires on the edge that leaves its final state.
  function automatic logic retires(input state_t s, input logic rdy);
    logic r;
    case (s)
      MEM_WB, ALU_WB, BRANCH: r = 1'b1;
      MEM_WR:                 r = rdy;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute over a shared-memory
// datapath, stalls on the memory handshake, counts retirements and traps bad opcodes.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t             r_state;
  state_t             w_next;
  logic               w_retire;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_instret;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; unreachable encodings fall into TRAP
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH: begin
        if (mem_ready) w_next = DECODE;
        else           w_next = FETCH;
      end
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next = MEM_ADDR;
          OP_RTYPE:          w_next = EXECUTE;
          OP_BRANCH:         w_next = BRANCH;
          default:           w_next = TRAP;
        endcase
      end
      MEM_ADDR: begin
        if (opcode == OP_LOAD)       w_next = MEM_RD;
        else if (opcode == OP_STORE) w_next = MEM_WR;
        else                         w_next = TRAP;
      end
      MEM_RD: begin
        if (mem_ready) w_next = MEM_WB;
        else           w_next = MEM_RD;
      end
      MEM_WB:  w_next = FETCH;
      MEM_WR: begin
        if (mem_ready) w_next = FETCH;
        else           w_next = MEM_WR;
      end
      EXECUTE: w_next = ALU_WB;
      ALU_WB:  w_next = FETCH;
      BRANCH:  w_next = FETCH;
      TRAP:    w_next = TRAP;
      default: w_next = TRAP;
    endcase
  end

  assign w_retire = retires(r_state, mem_ready);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end else begin
      r_instret <= r_instret;
    end
  end

  // Sticky trap flag, set on the edge that enters TRAP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_next == TRAP) begin
      r_illegal <= 1'b1;
    end else begin
      r_illegal <= r_illegal;
    end
  end

  assign instret = r_instret;

  // Output decode: Moore on state, except FETCH ir/pc writes gated by mem_ready
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    if (rst) begin
      illegal = 1'b0;
    end else begin
      illegal = r_illegal;
      case (r_state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = SRCB_IMM;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        ALU_WB: begin
          reg_write = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 1'b1;
        end
        TRAP:    illegal = r_illegal;
        default: illegal = r_illegal;
      endcase
    end
  end

endmodule
